// File: rtl/calc_operand_seq.sv
// calc_operand_seq
// ----------------
// Upstream sequencer for the 4-bit calculator ALU. It collects operand A, an
// opcode and operand B as a stream of W-bit tokens. It drives registered
// A/B/op into a combinational ALU. One cycle later it captures the ALU result
// and offers it downstream.
//
// Handshakes (both directions): a transfer happens at a rising edge of clk
// when valid && ready are both high. The producer holds the payload stable
// while valid is high and ready is low. ready never depends on valid.
//
// Optional feature, macro CALC_CHAIN_EN (accumulator mode): after a result
// transfer the sequencer goes to GET_OP and loads the result into alu_a, so
// the next calculation starts from the previous result. Without the macro,
// every calculation starts at GET_A.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   in_valid    token present on in_data
//   in_ready    sequencer accepts a token this cycle (GET_A/GET_OP/GET_B)
//   in_data     token: operand value, or opcode in bits [OPW-1:0]
//   abort       synchronous flush of the current calculation
//   alu_a       registered operand A to the ALU
//   alu_b       registered operand B to the ALU
//   alu_op      registered opcode (00 add, 01 sub, 10 or, 11 negate A)
//   alu_result  combinational ALU output
//   res_valid   result available
//   res_ready   downstream accepts result
//   res_data    captured result
//   err         one-cycle pulse after an illegal opcode token
//   dbg_state   current FSM state, for observation only

module calc_operand_seq #(
  parameter int W   = 4,
  parameter int OPW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic           abort,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [W-1:0]   alu_result,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [W-1:0]   res_data,
  output logic           err,
  output logic [2:0]     dbg_state
);

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_OP = 3'd1,
    GET_B  = 3'd2,
    EXEC   = 3'd3,
    HOLD   = 3'd4
  } state_e;

  localparam logic [OPW-1:0] OP_NEG = '1;

  state_e         state_q, state_d;
  logic [W-1:0]   alu_a_q, alu_a_d;
  logic [W-1:0]   alu_b_q, alu_b_d;
  logic [OPW-1:0] alu_op_q, alu_op_d;
  logic [W-1:0]   res_data_q, res_data_d;
  logic           res_valid_q, res_valid_d;
  logic           err_q, err_d;

  logic in_fire;
  logic res_fire;

  assign in_ready = (state_q == GET_A) || (state_q == GET_OP) || (state_q == GET_B);
  assign in_fire  = in_valid && in_ready;
  assign res_fire = res_valid_q && res_ready;

  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    err_d       = 1'b0;

    if (abort) begin
      // Flush wins over any transfer in the same cycle; operand registers
      // deliberately keep their contents.
      state_d     = GET_A;
      res_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        GET_A: begin
          if (in_fire) begin
            alu_a_d = in_data;
            state_d = GET_OP;
          end
        end

        GET_OP: begin
          if (in_fire) begin
            if (in_data[W-1:OPW] != '0) begin
              // Illegal opcode: drop the token, flag it, keep waiting.
              err_d = 1'b1;
            end else begin
              alu_op_d = in_data[OPW-1:0];
              if (in_data[OPW-1:0] == OP_NEG) begin
                // Negate is unary: no B token is expected.
                alu_b_d = '0;
                state_d = EXEC;
              end else begin
                state_d = GET_B;
              end
            end
          end
        end

        GET_B: begin
          if (in_fire) begin
            alu_b_d = in_data;
            state_d = EXEC;
          end
        end

        EXEC: begin
          // ALU inputs have been stable for the whole cycle.
          res_data_d  = alu_result;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end

        HOLD: begin
          if (res_fire) begin
            res_valid_d = 1'b0;
`ifdef CALC_CHAIN_EN
            alu_a_d = res_data_q;
            state_d = GET_OP;
`else
            state_d = GET_A;
`endif
          end
        end

        default: begin
          state_d     = GET_A;
          res_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= GET_A;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule
